// File: rtl/dtm_regs_param_if.sv
// DMI request/response bundle between the DTM register block and the DMI
// clock-domain crossing.
//
// Parameter: ABITS - DMI address width.
//
// master (DTM side): drives req_addr, req_data, req_op, req_valid, resp_ready;
//                    samples req_ready, resp_data, resp_resp, resp_valid.
// slave  (CDC side): the reverse.
interface dtm_regs_param_if #(
    parameter int ABITS = 7
);
    logic [ABITS-1:0] req_addr;
    logic [31:0]      req_data;
    logic [1:0]       req_op;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      resp_data;
    logic [1:0]       resp_resp;
    logic             resp_valid;
    logic             resp_ready;

    modport master (
        output req_addr, req_data, req_op, req_valid, resp_ready,
        input  req_ready, resp_data, resp_resp, resp_valid
    );

    modport slave (
        input  req_addr, req_data, req_op, req_valid, resp_ready,
        output req_ready, resp_data, resp_resp, resp_valid
    );
endinterface

// File: rtl/dtm_regs_param.sv
// Parametrised DTM register block: DTMCS and DMIACCESS shift/data registers
// between the JTAG TAP and the DMI CDC, one outstanding DMI request at a time,
// sticky dmistat errors, dmireset and dmihardreset.
//
// Optional build macro: DTM_RESP_TIMEOUT_EN adds a response watchdog that
// abandons a request after TIMEOUT_CYCLES cycles in REQ/WAIT.
//
// Ports:
//   tck_i            JTAG clock (only clock)
//   trst_i           synchronous active-high reset
//   capture_i        TAP Capture-DR
//   shift_i          TAP Shift-DR
//   update_i         TAP Update-DR
//   tdi_i            serial data in
//   dtmcs_select_i   IR selects DTMCS (wins over dmi_select_i)
//   dmi_select_i     IR selects DMIACCESS
//   jtag_dmi_clear_i TAP test-logic-reset clear
//   tdo_o            serial data out
//   dmi_clear_o      clear request to CDC/DM
//   dmi              DMI request/response bundle (master side)
//
// state   | meaning
// --------+------------------------------------------------
// ST_IDLE | no request outstanding
// ST_REQ  | req_valid high, waiting for req_ready
// ST_WAIT | request accepted, waiting for resp_valid
module dtm_regs_param #(
    parameter int ABITS          = 7,
    parameter int IDLE_CYCLES    = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             tck_i,
    input  logic             trst_i,
    input  logic             capture_i,
    input  logic             shift_i,
    input  logic             update_i,
    input  logic             tdi_i,
    input  logic             dtmcs_select_i,
    input  logic             dmi_select_i,
    input  logic             jtag_dmi_clear_i,
    output logic             tdo_o,
    output logic             dmi_clear_o,
    dtm_regs_param_if.master dmi
);
    localparam int         DMI_W       = ABITS + 34;
    localparam logic [1:0] OP_READ     = 2'd1;
    localparam logic [1:0] OP_WRITE    = 2'd2;
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_FAILED  = 2'd2;
    localparam logic [1:0] ERR_BUSY    = 2'd3;
    localparam logic [31:0] DATA_FAILED = 32'hB051B051;
    localparam logic [31:0] DATA_BUSY   = 32'hDEADBEEF;

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_chk
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      dtmcs_sr_q, dtmcs_sr_d;
    logic [DMI_W-1:0] dmi_sr_q, dmi_sr_d;
    logic [ABITS-1:0] addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic [1:0]       op_q, op_d;
    logic [1:0]       error_q, error_d;

    logic             busy;
    logic             dmi_sel;
    logic             hard_clear;
    logic             dmireset;
    logic             set_busy;
    logic             set_failed;
    logic             tmo_fire;
    logic [ABITS-1:0] upd_addr;
    logic [31:0]      upd_data;
    logic [1:0]       upd_op;

`ifdef DTM_RESP_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
    // cycles remaining before the watchdog fires; reloaded while idle
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
`else
    assign tmo_fire = 1'b0;
`endif

    assign busy       = (state_q != ST_IDLE);
    assign dmi_sel    = dmi_select_i & ~dtmcs_select_i;
    assign upd_addr   = dmi_sr_q[DMI_W-1:34];
    assign upd_data   = dmi_sr_q[33:2];
    assign upd_op     = dmi_sr_q[1:0];
    assign hard_clear = jtag_dmi_clear_i | (dtmcs_select_i & update_i & dtmcs_sr_q[17]);
    assign dmireset   = dtmcs_select_i & update_i & dtmcs_sr_q[16];

    assign dmi_clear_o = hard_clear | tmo_fire;
    assign tdo_o       = dtmcs_select_i ? dtmcs_sr_q[0] : dmi_sr_q[0];

    assign dmi.req_valid  = (state_q == ST_REQ);
    assign dmi.req_addr   = addr_q;
    assign dmi.req_data   = data_q;
    assign dmi.req_op     = op_q;
    assign dmi.resp_ready = 1'b1;

    always_comb begin
        state_d    = state_q;
        dtmcs_sr_d = dtmcs_sr_q;
        dmi_sr_d   = dmi_sr_q;
        addr_d     = addr_q;
        data_d     = data_q;
        op_d       = op_q;
        error_d    = error_q;
        set_busy   = 1'b0;
        set_failed = 1'b0;
`ifdef DTM_RESP_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
        tmo_fire   = 1'b0;
`endif

        if (dtmcs_select_i) begin
            if (capture_i) begin
                dtmcs_sr_d = {14'b0, 1'b0, 1'b0, 1'b0, 3'(IDLE_CYCLES), error_q,
                              6'(ABITS), 4'd1};
            end else if (shift_i) begin
                dtmcs_sr_d = {tdi_i, dtmcs_sr_q[31:1]};
            end
        end

        if (dmi_sel) begin
            if (capture_i) begin
                // capturing while a request is in flight reports busy and makes it sticky
                dmi_sr_d = {addr_q, data_q, busy ? ERR_BUSY : error_q};
                set_busy = busy;
            end else if (shift_i) begin
                dmi_sr_d = {tdi_i, dmi_sr_q[DMI_W-1:1]};
            end else if (update_i && error_q == ERR_NONE) begin
                if (busy) begin
                    set_busy = 1'b1;
                end else if (upd_op == OP_READ || upd_op == OP_WRITE) begin
                    addr_d  = upd_addr;
                    op_d    = upd_op;
                    state_d = ST_REQ;
                    if (upd_op == OP_WRITE) begin
                        data_d = upd_data;
                    end
                end
            end
        end

        case (state_q)
            ST_REQ: begin
                if (dmi.req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dmi.resp_valid) begin
                    state_d = ST_IDLE;
                    case (dmi.resp_resp)
                        2'd0: begin
                            if (op_q == OP_READ) begin
                                data_d = dmi.resp_data;
                            end
                        end
                        2'd3: begin
                            set_busy = 1'b1;
                            data_d   = DATA_BUSY;
                        end
                        default: begin
                            set_failed = 1'b1;
                            data_d     = DATA_FAILED;
                        end
                    endcase
                end
            end
            default: ;
        endcase

`ifdef DTM_RESP_TIMEOUT_EN
        if (state_q == ST_IDLE) begin
            tmo_cnt_d = TMO_LOAD;
        end else if ((state_q == ST_REQ && dmi.req_ready) ||
                     (state_q == ST_WAIT && dmi.resp_valid)) begin
            tmo_cnt_d = (tmo_cnt_q != '0) ? tmo_cnt_q - 1'b1 : tmo_cnt_q;
        end else if (tmo_cnt_q == '0) begin
            tmo_fire   = 1'b1;
            state_d    = ST_IDLE;
            set_failed = 1'b1;
            data_d     = DATA_FAILED;
        end else begin
            tmo_cnt_d = tmo_cnt_q - 1'b1;
        end
`endif

        // hard clear > failed > busy > dmireset
        if (hard_clear) begin
            error_d = ERR_NONE;
        end else if (set_failed) begin
            error_d = ERR_FAILED;
        end else if (set_busy) begin
            error_d = ERR_BUSY;
        end else if (dmireset) begin
            error_d = ERR_NONE;
        end

        if (hard_clear) begin
            state_d  = ST_IDLE;
            addr_d   = '0;
            data_d   = '0;
            dmi_sr_d = '0;
        end
    end

    always_ff @(posedge tck_i) begin
        if (trst_i) begin
            state_q    <= ST_IDLE;
            dtmcs_sr_q <= '0;
            dmi_sr_q   <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            op_q       <= OP_READ;
            error_q    <= ERR_NONE;
`ifdef DTM_RESP_TIMEOUT_EN
            tmo_cnt_q  <= TMO_LOAD;
`endif
        end else begin
            state_q    <= state_d;
            dtmcs_sr_q <= dtmcs_sr_d;
            dmi_sr_q   <= dmi_sr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            op_q       <= op_d;
            error_q    <= error_d;
`ifdef DTM_RESP_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
`endif
        end
    end
endmodule
